// File: rtl/decode_issue_fifo.sv
// decode_issue_fifo
// Decoupling queue between decode and issue. Holds decoded scoreboard
// entries together with the original instruction word and a ctrl-flow flag.
// Circular buffer of DEPTH entries (any DEPTH in 2..16); pointers wrap
// explicitly from DEPTH-1 to 0. There is no bypass path, so an entry pushed
// in one cycle is first presented in the next.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high. The upstream side pushes on in_valid_i & in_ready_o. The
// downstream side pops on out_valid_o & out_ack_i. in_ready_o depends only on
// occupancy, and out_valid_o only on occupancy and stall_i. A full queue
// refuses input even while the head is being popped. out_ack_i is ignored
// while out_valid_o is low.
//
// flush_i synchronously empties the queue. It takes priority over a
// same-cycle push or pop. A pushed entry in that cycle is consumed from
// decode's point of view, but it is discarded.
//
// Optional build macro DECODE_ISSUE_FIFO_PERF_EN adds two performance outputs:
// hwm_o is the occupancy high-water mark, and stall_cnt_o counts refused-input
// cycles and saturates.
module decode_issue_fifo #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [31:0]           in_instr_i,
  input  logic                  in_ctrl_flow_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [31:0]           out_instr_o,
  output logic                  out_ctrl_flow_o,
  input  logic                  out_ack_i,
  output logic [CW-1:0]         count_o,
  output logic                  full_o
`ifdef DECODE_ISSUE_FIFO_PERF_EN
  ,
  output logic [CW-1:0]         hwm_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef struct packed {
    logic                  ctrl_flow;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  entry_t        head;

  // Explicit wrap so non-power-of-two depths stay within the storage array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign in_ready_o  = (count != DEPTH_C);
  assign out_valid_o = (count != '0) && !stall_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ack_i;

  assign head            = mem[rd_ptr];
  assign out_data_o      = head.data;
  assign out_instr_o     = head.instr;
  assign out_ctrl_flow_o = head.ctrl_flow;
  assign count_o         = count;
  assign full_o          = (count == DEPTH_C);

  // Next pointers and occupancy; flush wins over any push or pop this cycle.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (push) begin
      wr_ptr_next = ptr_inc(wr_ptr);
    end
    if (pop) begin
      rd_ptr_next = ptr_inc(rd_ptr);
    end
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  // Pointer and occupancy registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Entry storage is not reset; a push that coincides with a flush is not written.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= '{ctrl_flow: in_ctrl_flow_i, instr: in_instr_i, data: in_data_i};
    end
  end

`ifdef DECODE_ISSUE_FIFO_PERF_EN
  logic [CW-1:0] hwm_q;
  logic [31:0]   stall_cnt_q;

  // High-water mark tracks the occupancy being loaded, so hwm_o >= count_o always;
  // refused-input cycles are counted with saturation. Only reset clears these.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hwm_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (count_next > hwm_q) begin
        hwm_q <= count_next;
      end
      if (in_valid_i && !in_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign hwm_o       = hwm_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

  a_count_le_depth: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= DEPTH_C);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (count != DEPTH_C));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    pop |-> (count != '0));

endmodule

// File: tb/tb_decode_issue_fifo.sv
// Bench for decode_issue_fifo: one DEPTH=4 instance and one DEPTH=3 instance.
// Directed stimulus drives the inputs. A per-instance monitor keeps an
// occupancy/entry model with the expected queue. It checks the handshake
// outputs every cycle and compares the head whenever a pop occurs.
module tb_decode_issue_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // ---------------- DEPTH=4 instance signals ----------------
  logic        d4_flush, d4_stall, d4_in_valid, d4_in_ready, d4_in_ctrl;
  logic [63:0] d4_in_data, d4_out_data;
  logic [31:0] d4_in_instr, d4_out_instr;
  logic        d4_out_valid, d4_out_ctrl, d4_ack, d4_full;
  logic [2:0]  d4_count;
`ifdef DECODE_ISSUE_FIFO_PERF_EN
  logic [2:0]  d4_hwm;
  logic [31:0] d4_stall_cnt;
`endif

  // ---------------- DEPTH=3 instance signals ----------------
  logic        d3_flush, d3_stall, d3_in_valid, d3_in_ready, d3_in_ctrl;
  logic [63:0] d3_in_data, d3_out_data;
  logic [31:0] d3_in_instr, d3_out_instr;
  logic        d3_out_valid, d3_out_ctrl, d3_ack, d3_full;
  logic [1:0]  d3_count;
`ifdef DECODE_ISSUE_FIFO_PERF_EN
  logic [1:0]  d3_hwm;
  logic [31:0] d3_stall_cnt;
`endif

  decode_issue_fifo #(.DATA_WIDTH(64), .DEPTH(4)) u_d4 (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (d4_flush),
    .stall_i         (d4_stall),
    .in_valid_i      (d4_in_valid),
    .in_ready_o      (d4_in_ready),
    .in_data_i       (d4_in_data),
    .in_instr_i      (d4_in_instr),
    .in_ctrl_flow_i  (d4_in_ctrl),
    .out_valid_o     (d4_out_valid),
    .out_data_o      (d4_out_data),
    .out_instr_o     (d4_out_instr),
    .out_ctrl_flow_o (d4_out_ctrl),
    .out_ack_i       (d4_ack),
    .count_o         (d4_count),
    .full_o          (d4_full)
`ifdef DECODE_ISSUE_FIFO_PERF_EN
    ,
    .hwm_o           (d4_hwm),
    .stall_cnt_o     (d4_stall_cnt)
`endif
  );

  decode_issue_fifo #(.DATA_WIDTH(64), .DEPTH(3)) u_d3 (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (d3_flush),
    .stall_i         (d3_stall),
    .in_valid_i      (d3_in_valid),
    .in_ready_o      (d3_in_ready),
    .in_data_i       (d3_in_data),
    .in_instr_i      (d3_in_instr),
    .in_ctrl_flow_i  (d3_in_ctrl),
    .out_valid_o     (d3_out_valid),
    .out_data_o      (d3_out_data),
    .out_instr_o     (d3_out_instr),
    .out_ctrl_flow_o (d3_out_ctrl),
    .out_ack_i       (d3_ack),
    .count_o         (d3_count),
    .full_o          (d3_full)
`ifdef DECODE_ISSUE_FIFO_PERF_EN
    ,
    .hwm_o           (d3_hwm),
    .stall_cnt_o     (d3_stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- common check ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic d4_put(input logic v, input logic [63:0] d);
    d4_in_valid = v;
    d4_in_data  = d;
    d4_in_instr = 32'hA500_0000 | d[31:0];
    d4_in_ctrl  = d[0];
  endtask

  task automatic d3_put(input logic v, input logic [63:0] d);
    d3_in_valid = v;
    d3_in_data  = d;
    d3_in_instr = 32'h5A00_0000 | d[31:0];
    d3_in_ctrl  = d[0];
  endtask

  // ---------------- scoreboards / monitors ----------------
  logic [96:0] exp_q[$];
  logic [96:0] exp_q3[$];
  int          m4_cnt, m4_hwm;
  int          m3_cnt, m3_hwm;
  logic [31:0] m4_stall, m3_stall;

  always @(negedge clk) begin : mon_d4
    logic mr, mv;
    if (rst) begin
      m4_cnt = 0; m4_hwm = 0; m4_stall = 0;
      exp_q.delete();
    end else begin
      mr = (m4_cnt < 4);
      mv = (m4_cnt != 0) && !d4_stall;
      check("d4_in_ready", 64'(d4_in_ready), 64'(mr));
      check("d4_out_valid", 64'(d4_out_valid), 64'(mv));
      check("d4_count", 64'(d4_count), 64'(m4_cnt));
      check("d4_full", 64'(d4_full), 64'(m4_cnt == 4));
`ifdef DECODE_ISSUE_FIFO_PERF_EN
      check("d4_hwm", 64'(d4_hwm), 64'(m4_hwm));
      check("d4_stall_cnt", 64'(d4_stall_cnt), 64'(m4_stall));
`endif
      if (mv && d4_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL d4_pop: got pop expected empty queue at %0t", $time);
        end else begin
          check("d4_out_data", d4_out_data, 64'(exp_q[0][63:0]));
          check("d4_out_instr", 64'(d4_out_instr), 64'(exp_q[0][95:64]));
          check("d4_out_ctrl", 64'(d4_out_ctrl), 64'(exp_q[0][96]));
        end
      end
      if (d4_in_valid && !mr && m4_stall != 32'hFFFF_FFFF) m4_stall = m4_stall + 1;
      if (d4_flush) begin
        exp_q.delete();
        m4_cnt = 0;
      end else begin
        if (mv && d4_ack && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          m4_cnt--;
        end
        if (d4_in_valid && mr) begin
          exp_q.push_back({d4_in_ctrl, d4_in_instr, d4_in_data});
          m4_cnt++;
        end
      end
      if (m4_cnt > m4_hwm) m4_hwm = m4_cnt;
    end
  end

  always @(negedge clk) begin : mon_d3
    logic mr, mv;
    if (rst) begin
      m3_cnt = 0; m3_hwm = 0; m3_stall = 0;
      exp_q3.delete();
    end else begin
      mr = (m3_cnt < 3);
      mv = (m3_cnt != 0) && !d3_stall;
      check("d3_in_ready", 64'(d3_in_ready), 64'(mr));
      check("d3_out_valid", 64'(d3_out_valid), 64'(mv));
      check("d3_count", 64'(d3_count), 64'(m3_cnt));
      check("d3_full", 64'(d3_full), 64'(m3_cnt == 3));
`ifdef DECODE_ISSUE_FIFO_PERF_EN
      check("d3_hwm", 64'(d3_hwm), 64'(m3_hwm));
      check("d3_stall_cnt", 64'(d3_stall_cnt), 64'(m3_stall));
`endif
      if (mv && d3_ack) begin
        if (exp_q3.size() == 0) begin
          checks++; failures++;
          $display("FAIL d3_pop: got pop expected empty queue at %0t", $time);
        end else begin
          check("d3_out_data", d3_out_data, 64'(exp_q3[0][63:0]));
          check("d3_out_instr", 64'(d3_out_instr), 64'(exp_q3[0][95:64]));
          check("d3_out_ctrl", 64'(d3_out_ctrl), 64'(exp_q3[0][96]));
        end
      end
      if (d3_in_valid && !mr && m3_stall != 32'hFFFF_FFFF) m3_stall = m3_stall + 1;
      if (d3_flush) begin
        exp_q3.delete();
        m3_cnt = 0;
      end else begin
        if (mv && d3_ack && exp_q3.size() != 0) begin
          void'(exp_q3.pop_front());
          m3_cnt--;
        end
        if (d3_in_valid && mr) begin
          exp_q3.push_back({d3_in_ctrl, d3_in_instr, d3_in_data});
          m3_cnt++;
        end
      end
      if (m3_cnt > m3_hwm) m3_hwm = m3_cnt;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    d4_flush = 0; d4_stall = 0; d4_ack = 0; d4_put(0, 64'h0);
    d3_flush = 0; d3_stall = 0; d3_ack = 0; d3_put(0, 64'h0);
    #3;
    check("rst_in_ready", 64'(d4_in_ready), 64'd1);
    check("rst_out_valid", 64'(d4_out_valid), 64'd0);
    check("rst_count", 64'(d4_count), 64'd0);
    check("rst_full", 64'(d4_full), 64'd0);
    check("rst_d3_count", 64'(d3_count), 64'd0);
    cyc(); cyc();
    rst = 0;

    // Single push: visible one cycle later.
    d4_put(1, 64'h11);
    #1;
    check("a_no_bypass", 64'(d4_out_valid), 64'd0);
    cyc();
    d4_put(0, 64'h0);
    check("a_out_valid", 64'(d4_out_valid), 64'd1);
    check("a_out_data", d4_out_data, 64'h11);
    check("a_count", 64'(d4_count), 64'd1);
    d4_ack = 1; cyc(); d4_ack = 0;
    check("a_count_after_pop", 64'(d4_count), 64'd0);

    // Fill to DEPTH, then two refused cycles, then the 5th goes in after a pop.
    for (int i = 0; i < 4; i++) begin
      d4_put(1, 64'h20 + 64'(i));
      cyc();
    end
    check("b_count_full", 64'(d4_count), 64'd4);
    check("b_full", 64'(d4_full), 64'd1);
    check("b_in_ready", 64'(d4_in_ready), 64'd0);
    d4_put(1, 64'h24);
    cyc(); cyc();
    check("b_count_held", 64'(d4_count), 64'd4);
`ifdef DECODE_ISSUE_FIFO_PERF_EN
    check("b_stall_cnt", 64'(d4_stall_cnt), 64'd2);
`endif
    d4_put(0, 64'h0); d4_ack = 1; cyc(); d4_ack = 0;
    check("b_count_pop", 64'(d4_count), 64'd3);
    check("b_ready_again", 64'(d4_in_ready), 64'd1);
    d4_put(1, 64'h24); cyc(); d4_put(0, 64'h0);
    check("b_count_refill", 64'(d4_count), 64'd4);
    d4_ack = 1; repeat (4) cyc(); d4_ack = 0;
    check("b_drained", 64'(d4_count), 64'd0);
    d4_flush = 1; cyc(); d4_flush = 0;
`ifdef DECODE_ISSUE_FIFO_PERF_EN
    check("b_hwm_kept", 64'(d4_hwm), 64'd4);
    check("b_stall_kept", 64'(d4_stall_cnt), 64'd2);
`endif

    // Push coinciding with flush at count=2.
    d4_put(1, 64'h31); cyc();
    d4_put(1, 64'h32); cyc();
    d4_put(1, 64'h33); d4_flush = 1;
    #1;
    check("c_ready_during_flush", 64'(d4_in_ready), 64'd1);
    cyc();
    d4_flush = 0; d4_put(0, 64'h0);
    check("c_count", 64'(d4_count), 64'd0);
    check("c_out_valid", 64'(d4_out_valid), 64'd0);
    d4_put(1, 64'h34); cyc(); d4_put(0, 64'h0);
    check("c_head_after_flush", d4_out_data, 64'h34);
    d4_ack = 1; cyc(); d4_ack = 0;

    // Stall masks the head for 3 cycles even with ack held.
    d4_put(1, 64'h41); cyc(); d4_put(0, 64'h0);
    d4_stall = 1; d4_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("d_stall_valid", 64'(d4_out_valid), 64'd0);
      cyc();
      check("d_stall_count", 64'(d4_count), 64'd1);
    end
    d4_stall = 0;
    #1;
    check("d_release_valid", 64'(d4_out_valid), 64'd1);
    check("d_release_data", d4_out_data, 64'h41);
    cyc();
    check("d_popped", 64'(d4_count), 64'd0);
    cyc();
    check("d_ack_empty", 64'(d4_count), 64'd0);
    d4_ack = 0;

    // DEPTH=3 wrap: 7 entries through a 2-deep steady state.
    d3_put(1, 64'h1); cyc();
    d3_put(1, 64'h2); cyc();
    check("e_count2", 64'(d3_count), 64'd2);
    d3_ack = 1;
    for (int v = 3; v <= 7; v++) begin
      d3_put(1, 64'(v)); cyc();
      check("e_count_steady", 64'(d3_count), 64'd2);
    end
    d3_put(0, 64'h0); cyc(); cyc(); d3_ack = 0;
    check("e_drained", 64'(d3_count), 64'd0);
    for (int v = 8; v <= 10; v++) begin
      d3_put(1, 64'(v)); cyc();
    end
    d3_put(0, 64'h0);
    check("e_full", 64'(d3_full), 64'd1);
    check("e_ready_low", 64'(d3_in_ready), 64'd0);
    d3_ack = 1; repeat (3) cyc(); d3_ack = 0;
    check("e_empty", 64'(d3_count), 64'd0);

    // Asynchronous reset mid-operation.
    d4_put(1, 64'h51); cyc();
    d4_put(1, 64'h52); cyc();
    d4_put(0, 64'h0);
    rst = 1;
    #1;
    check("f_async_count", 64'(d4_count), 64'd0);
    check("f_async_valid", 64'(d4_out_valid), 64'd0);
    check("f_async_ready", 64'(d4_in_ready), 64'd1);
    cyc();
    rst = 0;
    cyc();

    checks++;
    if (exp_q.size() != 0 || exp_q3.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d/%0d entries expected 0/0", exp_q.size(), exp_q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
